// File: rtl/bili_arty100t_top.sv
// Arty A7-100T "Bili" bring-up top: heartbeat LED, button-triggered 8N1 UART
// transmitter on JD[0], and a synchronized USB-UART echo on JD[3].
module bili_arty100t_top #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned LED_DIV    = 50_000_000,
  parameter int unsigned BAUD_DIV   = 868
) (
  input  logic       io_CLK100MHZ,
  input  logic       io_ck_rst,
  input  logic [3:0] io_sw,
  input  logic [3:0] io_btn,
  input  logic [7:0] io_ja,
  input  logic       io_jb,
  input  logic       io_jc,
  output logic       io_jd_0,
  input  logic       io_jd_1,
  input  logic       io_jd_2,
  output logic       io_jd_3,
  input  logic       io_jd_4,
  input  logic       io_jd_5,
  input  logic       io_jd_6,
  input  logic       io_jd_7,
  input  logic       io_uart_txd_in,
  input  logic       io_ck_ioa,
  input  logic       io_eth_col,
  input  logic       io_eth_crs,
  input  logic       io_eth_rx_clk,
  input  logic       io_eth_rx_dv,
  input  logic       io_eth_rxerr,
  input  logic       io_eth_tx_clk,
  input  logic [3:0] io_eth_rxd,
  output logic       io_led
);

  localparam int LW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [31:0] unused_freq = CLOCK_FREQ;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic rst;
  assign rst = ~io_ck_rst;

  logic [LW-1:0] led_cnt;
  logic          led;

  always_ff @(posedge io_CLK100MHZ) begin
    if (rst) begin
      led_cnt <= '0;
      led     <= 1'b0;
    end else if (led_cnt == LW'(LED_DIV - 1)) begin
      led_cnt <= '0;
      led     <= ~led;
    end else begin
      led_cnt <= led_cnt + 1'b1;
    end
  end

  // Button flops reset low so a button held through reset still yields one edge on release.
  logic btn_s1, btn_s2, btn_prev, uart_s1, uart_s2, pulse;

  always_ff @(posedge io_CLK100MHZ) begin
    if (rst) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
      uart_s1  <= 1'b1;
      uart_s2  <= 1'b1;
    end else begin
      btn_s1   <= io_btn[0];
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      uart_s1  <= io_uart_txd_in;
      uart_s2  <= uart_s1;
    end
  end

  assign pulse = btn_s2 & ~btn_prev;

  tx_state_t     state, state_d;
  logic [BW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    data, data_d;
  logic          line, line_d;
  logic          baud_done;

  assign baud_done = (cnt == BW'(BAUD_DIV - 1));

  always_ff @(posedge io_CLK100MHZ) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      data    <= '0;
      line    <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      data    <= data_d;
      line    <= line_d;
    end
  end

  // The line level is derived from the next state so the registered output lines up with it.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    data_d  = data;
    line_d  = 1'b1;
    case (state)
      IDLE: begin
        if (pulse) begin
          state_d = START;
          cnt_d   = '0;
          data_d  = {io_sw, io_ja[3:0]};
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) state_d = STOP;
          else                 bit_d   = bit_idx + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = data_d[bit_d];
      default: line_d = 1'b1;
    endcase
  end

  assign io_led  = led;
  assign io_jd_0 = line;
  assign io_jd_3 = uart_s2;

  logic unused;
  assign unused = ^{io_btn[3:1], io_ja[7:4], io_jb, io_jc, io_jd_1, io_jd_2,
                    io_jd_4, io_jd_5, io_jd_6, io_jd_7, io_ck_ioa, io_eth_col,
                    io_eth_crs, io_eth_rx_clk, io_eth_rx_dv, io_eth_rxerr,
                    io_eth_tx_clk, io_eth_rxd, unused_freq[0]};

endmodule

// File: tb/tb_bili_arty100t_top.sv
// Directed self-checking bench for bili_arty100t_top with shortened LED and
// baud dividers; expected levels are hand-derived cycle by cycle.
module tb_bili_arty100t_top;

  localparam int LED_DIV  = 100;
  localparam int BAUD_DIV = 4;

  logic       clk = 1'b0;
  logic       ck_rst = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [3:0] btn = 4'h0;
  logic [7:0] ja = 8'h00;
  logic       uart_in = 1'b0;
  logic       jb = 1'bx, jc = 1'bz, ck_ioa = 1'b1;
  logic       jd_1 = 1'b1, jd_2 = 1'bx, jd_4 = 1'b0, jd_5 = 1'bz, jd_6 = 1'b1, jd_7 = 1'b0;
  logic       eth_col = 1'bx, eth_crs = 1'b1, eth_rx_clk = 1'b0, eth_rx_dv = 1'bz;
  logic       eth_rxerr = 1'b1, eth_tx_clk = 1'bx;
  logic [3:0] eth_rxd = 4'b1x0z;
  logic       jd_0, jd_3, led;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bili_arty100t_top #(
    .CLOCK_FREQ(100_000_000),
    .LED_DIV   (LED_DIV),
    .BAUD_DIV  (BAUD_DIV)
  ) dut (
    .io_CLK100MHZ  (clk),
    .io_ck_rst     (ck_rst),
    .io_sw         (sw),
    .io_btn        (btn),
    .io_ja         (ja),
    .io_jb         (jb),
    .io_jc         (jc),
    .io_jd_0       (jd_0),
    .io_jd_1       (jd_1),
    .io_jd_2       (jd_2),
    .io_jd_3       (jd_3),
    .io_jd_4       (jd_4),
    .io_jd_5       (jd_5),
    .io_jd_6       (jd_6),
    .io_jd_7       (jd_7),
    .io_uart_txd_in(uart_in),
    .io_ck_ioa     (ck_ioa),
    .io_eth_col    (eth_col),
    .io_eth_crs    (eth_crs),
    .io_eth_rx_clk (eth_rx_clk),
    .io_eth_rx_dv  (eth_rx_dv),
    .io_eth_rxerr  (eth_rxerr),
    .io_eth_tx_clk (eth_tx_clk),
    .io_eth_rxd    (eth_rxd),
    .io_led        (led)
  );

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advance n rising edges, leaving the bench 1 time unit after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic frameBit(input logic [7:0] b, input int j);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[j / BAUD_DIV];
  endfunction

  initial begin
    // Reset state
    applyStimulus(10);
    checkOutput("reset led", led, 1'b0);
    checkOutput("reset tx line", jd_0, 1'b1);
    checkOutput("reset echo", jd_3, 1'b1);

    // Heartbeat timing and echo latency after release
    ck_rst = 1'b1;
    applyStimulus(1);
    checkOutput("echo lat 1", jd_3, 1'b1);
    applyStimulus(1);
    checkOutput("echo lat 2", jd_3, 1'b0);
    applyStimulus(97);
    checkOutput("led 99", led, 1'b0);
    applyStimulus(1);
    checkOutput("led rise 100", led, 1'b1);
    applyStimulus(99);
    checkOutput("led 199", led, 1'b1);
    applyStimulus(1);
    checkOutput("led fall 200", led, 1'b0);
    applyStimulus(99);
    checkOutput("led 299", led, 1'b0);
    applyStimulus(1);
    checkOutput("led rise 300", led, 1'b1);
    checkOutput("idle tx line", jd_0, 1'b1);
    applyStimulus(50);
    ck_rst = 1'b0;
    applyStimulus(1);
    checkOutput("led reset", led, 1'b0);
    applyStimulus(1);
    ck_rst = 1'b1;
    applyStimulus(99);
    checkOutput("led restart 99", led, 1'b0);
    applyStimulus(1);
    checkOutput("led restart 100", led, 1'b1);

    // Frame 0xA5, dropped press during DATA, back-to-back frame 0x3C
    sw = 4'hA;
    ja = 8'hF5;
    btn[0] = 1'b1;
    for (int t = 1; t <= 90; t++) begin
      applyStimulus(1);
      if (t < 3)       checkOutput("pre-start", jd_0, 1'b1);
      else if (t < 43) checkOutput($sformatf("frameA5 j=%0d", t - 3), jd_0, frameBit(8'hA5, t - 3));
      else if (t == 43) checkOutput("gap idle", jd_0, 1'b1);
      else if (t < 84) checkOutput($sformatf("frame3C j=%0d", t - 44), jd_0, frameBit(8'h3C, t - 44));
      else             checkOutput("post idle", jd_0, 1'b1);
      case (t)
        13: begin sw = 4'h3; ja = 8'h2C; end
        20: btn[0] = 1'b0;
        27: btn[0] = 1'b1;
        31: btn[0] = 1'b0;
        41: btn[0] = 1'b1;
        60: begin btn[0] = 1'b0; sw = 4'hF; ja = 8'h00; end
        default: ;
      endcase
    end

    // Reset during DATA aborts the frame; nothing resumes afterwards
    sw = 4'h0;
    ja = 8'h00;
    btn[0] = 1'b1;
    for (int t = 1; t <= 70; t++) begin
      applyStimulus(1);
      if (t < 3)        checkOutput("abort pre", jd_0, 1'b1);
      else if (t <= 10) checkOutput($sformatf("abort frame t=%0d", t), jd_0, 1'b0);
      else              checkOutput($sformatf("abort idle t=%0d", t), jd_0, 1'b1);
      if (t == 10) begin
        ck_rst = 1'b0;
        btn[0] = 1'b0;
      end
      if (t == 12) ck_rst = 1'b1;
    end

    // Echo 0 -> 1 -> 0 with two-cycle latency, then reset presets it high
    uart_in = 1'b1;
    applyStimulus(1);
    checkOutput("echo rise +1", jd_3, 1'b0);
    applyStimulus(1);
    checkOutput("echo rise +2", jd_3, 1'b1);
    applyStimulus(1);
    uart_in = 1'b0;
    applyStimulus(1);
    checkOutput("echo fall +1", jd_3, 1'b1);
    applyStimulus(1);
    checkOutput("echo fall +2", jd_3, 1'b0);
    ck_rst = 1'b0;
    applyStimulus(1);
    checkOutput("echo reset", jd_3, 1'b1);
    checkOutput("led final reset", led, 1'b0);
    ck_rst = 1'b1;
    applyStimulus(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
